xy_draw_scheduler: RTL
======================

XY_DRAW_SCHEDULER -- requirements
Module: xy_draw_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- Y_MAX, 220, top drawable Y code.
- PLATE_HALFWIDTH, 15, plate half-length in Y codes.
- BALL_DWELL, 16, cycles the ball point is held (1..255).
- SETTLE, 4, blanked settle cycles before each slot (1..255).
- STEP_DIV, 1, cycles per plate sweep point (1..255).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, run frames while high.
- x_b, in, 8, ball X.
- y_b, in, 8, ball Y.
- y_l_mid, in, 8, left plate centre Y.
- y_r_mid, in, 8, right plate centre Y.
- x_out, out, 8, DAC X code.
- y_out, out, 8, DAC Y code.
- blank, out, 1, beam blank (1 = blanked).
- src, out, 2, slot: 0 ball, 1 left, 2 right, 3 idle.
- frame_tick, out, 1, one-cycle pulse at frame end.

Function
REQ-003 The block SHALL time-share one XY DAC between three sources: ball point, left plate (X=0), and right plate (X=255).
REQ-004 The FSM SHALL have states IDLE, SET_B, BALL, SET_L, LEFT, SET_R, RIGHT.
REQ-005 FSM transitions SHALL be:
- IDLE->SET_B when en=1.
- SET_x->slot x after SETTLE cycles.
- BALL->SET_L after BALL_DWELL cycles.
- LEFT->SET_R at sweep end.
- RIGHT->SET_B if en=1, else IDLE.
REQ-006 en SHALL only be sampled in IDLE and at RIGHT completion; deasserting en mid-frame SHALL let the frame finish.
REQ-007 On entry to each SET_x state, the source inputs SHALL be latched; the slot SHALL use only latched values so that input changes never tear a slot.
REQ-008 Plate range SHALL be computed from mid clamped to Y_MAX:
- min = mid>=PLATE_HALFWIDTH ? mid-PLATE_HALFWIDTH : 0.
- max = mid<=Y_MAX-PLATE_HALFWIDTH ? mid+PLATE_HALFWIDTH : Y_MAX.
- Arithmetic is 8-bit unsigned with no wrap.
REQ-009 During SET_x, x_out/y_out SHALL already hold the first point of slot x (ball position, or plate X with y=min), with blank=1 and src = the upcoming slot.
REQ-010 During BALL, x_out=x_b latched, y_out=y_b latched, blank=0, src=0.
REQ-011 During LEFT/RIGHT, x_out SHALL be 0/255 and y_out SHALL step from min to max inclusive, incrementing every STEP_DIV cycles; the slot lasts (max-min+1)*STEP_DIV cycles; blank=0.
REQ-012 A frame in which every plate is unclamped SHALL last 3*SETTLE + BALL_DWELL + 2*(2*PLATE_HALFWIDTH+1)*STEP_DIV cycles.
REQ-013 frame_tick SHALL be high for exactly the last cycle of RIGHT.
REQ-014 In IDLE, outputs SHALL be blank=1, src=3, and x_out/y_out holding their last values.
REQ-015 All outputs SHALL be registered; the first SET_B cycle SHALL appear one cycle after en is sampled high in IDLE.

Reset
REQ-016 While rst_n=0, state=IDLE, x_out=0, y_out=0, blank=1, src=3, frame_tick=0, and all counters and latches SHALL be 0.
REQ-017 Reset asserted mid-slot SHALL abort immediately; after release the block SHALL restart from IDLE.

Structure
REQ-018 The state encoding, the src codes, and the X_LEFT=0 / X_RIGHT=255 constants SHALL live in the shared pong package.
REQ-019 A single sub-module, plate_range, SHALL compute the min/max of REQ-008 and SHALL be instantiated twice (left and right plates).

Verification
REQ-020 Defaults, en=1, y_l_mid=100, y_r_mid=5, x_b=40, y_b=60 -> frame of 12+16+31+21=80 cycles; left sweeps 85..115; right sweeps 0..20; frame_tick every 80 cycles.
REQ-021 y_r_mid=250 -> range clamped to 205..220 (16 points); no Y value above 220 appears.
REQ-022 en dropped during LEFT -> RIGHT completes, frame_tick pulses once, then IDLE with blank=1 and src=3.
REQ-023 y_b changed mid-BALL -> y_out is unchanged until the next SET_B.
REQ-024 rst_n pulsed low during RIGHT -> outputs immediately take reset values; the next frame begins one cycle after rst_n is released and en is sampled high.
REQ-025 STEP_DIV=3 -> each plate Y is held exactly 3 cycles; the left slot lasts 93 cycles for an unclamped plate.

Source files
------------

// File: rtl/xy_draw_scheduler_pkg.sv
// Shared definitions for the XY draw scheduler: FSM state encoding, slot
// source codes and the fixed X positions of the two plates.
package xy_draw_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET_B = 3'd1,
        ST_BALL  = 3'd2,
        ST_SET_L = 3'd3,
        ST_LEFT  = 3'd4,
        ST_SET_R = 3'd5,
        ST_RIGHT = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SRC_BALL  = 2'd0,
        SRC_LEFT  = 2'd1,
        SRC_RIGHT = 2'd2,
        SRC_IDLE  = 2'd3
    } src_t;

    localparam logic [7:0] X_LEFT  = 8'd0;
    localparam logic [7:0] X_RIGHT = 8'd255;

endpackage

// File: rtl/xy_draw_scheduler_if.sv
// Source inputs and DAC outputs of the XY draw scheduler; the scheduler is the
// slave side, whoever feeds positions and consumes the DAC codes is the master.
interface xy_draw_scheduler_if;
    logic       en;
    logic [7:0] x_b;
    logic [7:0] y_b;
    logic [7:0] y_l_mid;
    logic [7:0] y_r_mid;
    logic [7:0] x_out;
    logic [7:0] y_out;
    logic       blank;
    logic [1:0] src;
    logic       frame_tick;

    modport master (
        output en, x_b, y_b, y_l_mid, y_r_mid,
        input  x_out, y_out, blank, src, frame_tick
    );

    modport slave (
        input  en, x_b, y_b, y_l_mid, y_r_mid,
        output x_out, y_out, blank, src, frame_tick
    );
endinterface

// File: rtl/xy_draw_scheduler_plate_range.sv
// Y extent of one plate: centre clamped to the drawable area, then widened by
// the half-width on each side without leaving 0..Y_MAX.
module plate_range
    import xy_draw_scheduler_pkg::*;
#(
    parameter int Y_MAX     = 220,
    parameter int HALFWIDTH = 15
) (
    input  logic [7:0] mid,
    output logic [7:0] y_min,
    output logic [7:0] y_max
);
    localparam logic [7:0] Y_TOP    = 8'(Y_MAX);
    localparam logic [7:0] HW       = 8'(HALFWIDTH);
    localparam logic [7:0] HI_LIMIT = 8'(Y_MAX - HALFWIDTH);

    logic [7:0] mid_c;

    always_comb begin
        mid_c = (mid > Y_TOP) ? Y_TOP : mid;
        y_min = (mid_c >= HW) ? mid_c - HW : 8'd0;
        y_max = (mid_c <= HI_LIMIT) ? mid_c + HW : Y_TOP;
    end
endmodule

// File: rtl/xy_draw_scheduler.sv
// Time-shares one XY DAC between the ball point and the two plates, frame by
// frame: settle, ball dwell, settle, left sweep, settle, right sweep.
module xy_draw_scheduler
    import xy_draw_scheduler_pkg::*;
#(
    parameter int Y_MAX           = 220,
    parameter int PLATE_HALFWIDTH = 15,
    parameter int BALL_DWELL      = 16,
    parameter int SETTLE          = 4,
    parameter int STEP_DIV        = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    xy_draw_scheduler_if.slave bus
);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0] DWELL_LAST  = 8'(BALL_DWELL - 1);
    localparam logic [7:0] STEP_LAST   = 8'(STEP_DIV - 1);

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [7:0] div_reg, div_next;
    logic [7:0] x_out_reg, x_out_next;
    logic [7:0] y_out_reg, y_out_next;
    logic       blank_reg, blank_next;
    src_t       src_reg, src_next;
    logic       tick_reg, tick_next;
    logic [7:0] xb_lat_reg, xb_lat_next;
    logic [7:0] yb_lat_reg, yb_lat_next;
    logic [7:0] l_max_reg, l_max_next;
    logic [7:0] r_max_reg, r_max_next;
    logic       go_set_b, go_set_l, go_set_r;

    // Index 0 is the left plate, index 1 the right plate.
    logic [7:0] mid_arr [2];
    logic [7:0] min_arr [2];
    logic [7:0] max_arr [2];

    assign mid_arr[0] = bus.y_l_mid;
    assign mid_arr[1] = bus.y_r_mid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_plate
            plate_range #(
                .Y_MAX     (Y_MAX),
                .HALFWIDTH (PLATE_HALFWIDTH)
            ) u_range (
                .mid   (mid_arr[gi]),
                .y_min (min_arr[gi]),
                .y_max (max_arr[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        div_next    = div_reg;
        x_out_next  = x_out_reg;
        y_out_next  = y_out_reg;
        blank_next  = blank_reg;
        src_next    = src_reg;
        xb_lat_next = xb_lat_reg;
        yb_lat_next = yb_lat_reg;
        l_max_next  = l_max_reg;
        r_max_next  = r_max_reg;
        go_set_b    = 1'b0;
        go_set_l    = 1'b0;
        go_set_r    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                blank_next = 1'b1;
                src_next   = SRC_IDLE;
                if (bus.en) go_set_b = 1'b1;
            end
            ST_SET_B, ST_SET_L, ST_SET_R: begin
                if (cnt_reg == SETTLE_LAST) begin
                    cnt_next   = 8'd0;
                    div_next   = 8'd0;
                    blank_next = 1'b0;
                    state_next = (state_reg == ST_SET_B) ? ST_BALL :
                                 (state_reg == ST_SET_L) ? ST_LEFT : ST_RIGHT;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            ST_BALL: begin
                x_out_next = xb_lat_reg;
                y_out_next = yb_lat_reg;
                if (cnt_reg == DWELL_LAST) go_set_l = 1'b1;
                else                       cnt_next = cnt_reg + 8'd1;
            end
            ST_LEFT: begin
                if (div_reg == STEP_LAST) begin
                    div_next = 8'd0;
                    if (y_out_reg == l_max_reg) go_set_r = 1'b1;
                    else                        y_out_next = y_out_reg + 8'd1;
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            ST_RIGHT: begin
                if (div_reg == STEP_LAST) begin
                    div_next = 8'd0;
                    if (y_out_reg == r_max_reg) begin
                        // en is looked at only here and in IDLE, so frames never stop midway.
                        if (bus.en) begin
                            go_set_b = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                            blank_next = 1'b1;
                            src_next   = SRC_IDLE;
                        end
                    end else begin
                        y_out_next = y_out_reg + 8'd1;
                    end
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Slot entry: latch the sources and preload the first point while blanked.
        if (go_set_b) begin
            state_next  = ST_SET_B;
            cnt_next    = 8'd0;
            xb_lat_next = bus.x_b;
            yb_lat_next = bus.y_b;
            x_out_next  = bus.x_b;
            y_out_next  = bus.y_b;
            blank_next  = 1'b1;
            src_next    = SRC_BALL;
        end
        if (go_set_l) begin
            state_next = ST_SET_L;
            cnt_next   = 8'd0;
            l_max_next = max_arr[0];
            x_out_next = X_LEFT;
            y_out_next = min_arr[0];
            blank_next = 1'b1;
            src_next   = SRC_LEFT;
        end
        if (go_set_r) begin
            state_next = ST_SET_R;
            cnt_next   = 8'd0;
            r_max_next = max_arr[1];
            x_out_next = X_RIGHT;
            y_out_next = min_arr[1];
            blank_next = 1'b1;
            src_next   = SRC_RIGHT;
        end

        // Registered tick: asserted for the cycle that will be the last RIGHT point.
        tick_next = (state_next == ST_RIGHT) && (y_out_next == r_max_next) &&
                    (div_next == STEP_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 8'd0;
            div_reg    <= 8'd0;
            x_out_reg  <= 8'd0;
            y_out_reg  <= 8'd0;
            blank_reg  <= 1'b1;
            src_reg    <= SRC_IDLE;
            tick_reg   <= 1'b0;
            xb_lat_reg <= 8'd0;
            yb_lat_reg <= 8'd0;
            l_max_reg  <= 8'd0;
            r_max_reg  <= 8'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            div_reg    <= div_next;
            x_out_reg  <= x_out_next;
            y_out_reg  <= y_out_next;
            blank_reg  <= blank_next;
            src_reg    <= src_next;
            tick_reg   <= tick_next;
            xb_lat_reg <= xb_lat_next;
            yb_lat_reg <= yb_lat_next;
            l_max_reg  <= l_max_next;
            r_max_reg  <= r_max_next;
        end
    end

    assign bus.x_out      = x_out_reg;
    assign bus.y_out      = y_out_reg;
    assign bus.blank      = blank_reg;
    assign bus.src        = src_reg;
    assign bus.frame_tick = tick_reg;
endmodule
